drum_voice_scheduler: RTL and testbench
=======================================

// Module: drum_voice_scheduler
// PURPOSE
//  Polyphonic playback scheduler for the drum sampler. It accepts drum triggers
//  (start address plus invalid flag from the drum keymapper), assigns each one to
//  one of NUM_VOICES playback voices, and advances every active voice once per
//  sample_tick. It shares the single sample-memory read port among the voices,
//  round-robin per frame, and emits one saturated mixed sample per frame to the audio path.
// PARAMETERS
//  NUM_VOICES  4        playback voices; power of 2, 2..8
//  ADDR_W      20       sample-memory word address width
//  DATA_W      16       signed sample width (two's complement)
//  SAMPLE_LEN  32768    words played per trigger before the voice frees itself
// PORTS
//  Clk           in   1           system clock
//  Reset         in   1           synchronous, active-high reset
//  trig          in   1           1-cycle pulse: new key press
//  trig_addr     in   ADDR_W      drum start address (keymapper note_addr)
//  trig_invalid  in   1           keymapper invalid_note; trigger is ignored when 1
//  sample_tick   in   1           1-cycle pulse at audio sample rate, starts a frame
//  mem_req       out  1           read request to sample memory
//  mem_addr      out  ADDR_W      read address; valid while mem_req=1
//  mem_ack       in   1           read complete; mem_data valid this cycle
//  mem_data      in   DATA_W      signed sample word
//  mix_out       out  DATA_W      saturated sum of all active voices
//  mix_valid     out  1           1-cycle pulse when mix_out updates
//  voice_active  out  NUM_VOICES  bit v = voice v playing
//  overrun       out  1           sticky; a sample_tick arrived while a frame was busy
// BEHAVIOUR
//  Reset: all voices idle (base=0, offset=0), steal_ptr=0, pending trigger cleared,
//   mem_req=0, mem_addr=0, mix_out=0, mix_valid=0, voice_active=0, overrun=0, FSM=IDLE.
//   Reset mid-fetch drops mem_req on the next edge. A late mem_ack after reset is ignored.
//  Trigger capture: trig=1 with trig_invalid=0 loads a one-entry pending register
//   {addr}. A newer trigger overwrites an unapplied one. trig with trig_invalid=1 is ignored.
//  Allocation happens only in IDLE, one cycle after the pending trigger is set.
//   - Target is the lowest-index idle voice.
//   - If all voices are busy, target = steal_ptr, then steal_ptr++ (mod NUM_VOICES).
//   - Target is loaded with base=addr, offset=0, active=1; pending is cleared.
//   - If sample_tick and apply occur in the same cycle, apply first; the frame
//     starts the next cycle and includes the new voice.
//  FSM states: IDLE -> SCAN(v) -> [REQ(v) -> WAIT(v)] -> DONE -> IDLE.
//   IDLE: on sample_tick, clear the accumulator and go to SCAN(0).
//   SCAN(v): if the voice is inactive, skip (1 cycle) to v+1. Otherwise go to REQ.
//   REQ: drive mem_req=1 and mem_addr=base+offset (wraps mod 2^ADDR_W).
//    mem_req/mem_addr are held stable until mem_ack. mem_ack is ignored while mem_req=0.
//   WAIT/ack: acc += sign-extended mem_data; offset++.
//    If offset was SAMPLE_LEN-1, clear active.
//    Deassert mem_req the cycle after ack, then go to SCAN(v+1), or DONE after the last voice.
//   DONE: mix_out = acc saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; mix_valid=1 for 1 cycle.
//  Accumulator width: DATA_W+log2(NUM_VOICES); no internal overflow is possible.
//  A frame with no active voices never asserts mem_req.
//   It still produces mix_out=0 and mix_valid, NUM_VOICES+2 cycles after the tick.
//  sample_tick outside IDLE: the tick is dropped and overrun is set (cleared only by Reset).
//  A trigger arriving during a frame waits in pending until IDLE; it never alters the voice being fetched.
// TESTING
//  1 Reset, then sample_tick with no triggers -> mem_req stays 0; mix_valid after 6 cycles
//    (N=4); mix_out=0.
//  2 trig addr=0x79230, then tick; memory acks 1 cycle after req with 0x1234 ->
//    mem_addr=0x79230, mix_out=0x1234. Next tick -> mem_addr=0x79231.
//  3 Two voices (0x60EE0, 0x996F8) both returning 0x7000 -> mix_out=0x7FFF.
//    Both returning 0x9000 -> mix_out=0x8000.
//  4 trig with trig_invalid=1 -> voice_active unchanged, no mem_req.
//    Five valid triggers -> voice_active=4'b1111, and the 5th reloads voice 0 with offset 0.
//  5 SAMPLE_LEN=4, one trigger, 4 ticks -> voice_active[0] clears after the 4th ack.
//    5th frame has no mem_req.
//  6 sample_tick while in WAIT -> overrun=1, frame completes normally.
//    Reset asserted in WAIT -> mem_req=0 next cycle; all outputs at reset values.

Source files
------------

// File: rtl/drum_voice_scheduler.sv
// rtl/drum_voice_scheduler.sv - polyphonic drum voice scheduler with shared sample-memory port and saturating mixer
// Allocates triggers to voices and fetches one word per active voice per sample frame.
module drum_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 20,
    parameter int DATA_W     = 16,
    parameter int SAMPLE_LEN = 32768
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  trig,
    input  logic [ADDR_W-1:0]     trig_addr,
    input  logic                  trig_invalid,
    input  logic                  sample_tick,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_data,
    output logic [DATA_W-1:0]     mix_out,
    output logic                  mix_valid,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  overrun
);

    localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int OFF_W = (SAMPLE_LEN > 1) ? $clog2(SAMPLE_LEN) : 1;
    localparam int ACC_W = DATA_W + VW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [VW-1:0]           vidx_q, vidx_d;
    logic [VW-1:0]           steal_q, steal_d;
    logic                    pend_q, pend_d;
    logic [ADDR_W-1:0]       pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0]       base_q   [NUM_VOICES];
    logic [ADDR_W-1:0]       base_d   [NUM_VOICES];
    logic [OFF_W-1:0]        offset_q [NUM_VOICES];
    logic [OFF_W-1:0]        offset_d [NUM_VOICES];
    logic [NUM_VOICES-1:0]   active_q, active_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic                    mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]       mix_out_q, mix_out_d;
    logic                    mix_valid_q, mix_valid_d;
    logic                    overrun_q, overrun_d;

    logic                    free_found;
    logic [VW-1:0]           free_idx;
    logic [VW-1:0]           target;
    logic                    trig_ok;
    logic                    last_voice;
    logic                    acc_in_range;
    logic [DATA_W-1:0]       acc_sat;

    // Lowest-index idle voice wins; scanning downward leaves the lowest one.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!active_q[v]) begin
                free_found = 1'b1;
                free_idx   = VW'(v);
            end
        end
    end

    assign trig_ok    = trig && !trig_invalid;
    assign target     = free_found ? free_idx : steal_q;
    assign last_voice = (vidx_q == VW'(NUM_VOICES - 1));

    // The sum fits DATA_W bits only when all bits above the DATA_W sign bit agree.
    assign acc_in_range = (&acc_q[ACC_W-1:DATA_W-1]) || !(|acc_q[ACC_W-1:DATA_W-1]);
    assign acc_sat = acc_in_range ? acc_q[DATA_W-1:0]
                   : acc_q[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                    : {1'b0, {(DATA_W-1){1'b1}}};

    always_comb begin
        state_d     = state_q;
        vidx_d      = vidx_q;
        steal_d     = steal_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        base_d      = base_q;
        offset_d    = offset_q;
        active_d    = active_q;
        acc_d       = acc_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mix_out_d   = mix_out_q;
        mix_valid_d = 1'b0;
        overrun_d   = overrun_q;

        if (sample_tick && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    if (!free_found) begin
                        steal_d = steal_q + VW'(1);
                    end
                    base_d[target]   = pend_addr_q;
                    offset_d[target] = '0;
                    active_d[target] = 1'b1;
                    pend_d           = 1'b0;
                end
                if (sample_tick) begin
                    acc_d   = '0;
                    vidx_d  = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (active_q[vidx_q]) begin
                    state_d = S_REQ;
                end else if (last_voice) begin
                    state_d = S_DONE;
                end else begin
                    vidx_d = vidx_q + VW'(1);
                end
            end
            S_REQ: begin
                mem_req_d  = 1'b1;
                mem_addr_d = base_q[vidx_q] + ADDR_W'(offset_q[vidx_q]);
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (mem_req_q && mem_ack) begin
                    acc_d            = acc_q + {{VW{mem_data[DATA_W-1]}}, mem_data};
                    offset_d[vidx_q] = offset_q[vidx_q] + OFF_W'(1);
                    if (offset_q[vidx_q] == OFF_W'(SAMPLE_LEN - 1)) begin
                        active_d[vidx_q] = 1'b0;
                    end
                    mem_req_d = 1'b0;
                    if (last_voice) begin
                        state_d = S_DONE;
                    end else begin
                        vidx_d  = vidx_q + VW'(1);
                        state_d = S_SCAN;
                    end
                end
            end
            S_DONE: begin
                mix_out_d   = acc_sat;
                mix_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A fresh trigger always lands in pending, even in the cycle an older one is applied.
        if (trig_ok) begin
            pend_d      = 1'b1;
            pend_addr_d = trig_addr;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            vidx_q      <= '0;
            steal_q     <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                base_q[v]   <= '0;
                offset_q[v] <= '0;
            end
            active_q    <= '0;
            acc_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            vidx_q      <= vidx_d;
            steal_q     <= steal_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            base_q      <= base_d;
            offset_q    <= offset_d;
            active_q    <= active_d;
            acc_q       <= acc_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign mix_out      = mix_out_q;
    assign mix_valid    = mix_valid_q;
    assign voice_active = active_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_drum_voice_scheduler.sv
// tb/tb_drum_voice_scheduler.sv - scoreboard bench for drum_voice_scheduler
module tb_drum_voice_scheduler;

    localparam int NV = 4;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int SL = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          trig;
    logic [AW-1:0] trig_addr;
    logic          trig_invalid;
    logic          sample_tick;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] mix_out;
    logic          mix_valid;
    logic [NV-1:0] voice_active;
    logic          overrun;

    drum_voice_scheduler #(
        .NUM_VOICES (NV),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .SAMPLE_LEN (SL)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .trig         (trig),
        .trig_addr    (trig_addr),
        .trig_invalid (trig_invalid),
        .sample_tick  (sample_tick),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .mix_out      (mix_out),
        .mix_valid    (mix_valid),
        .voice_active (voice_active),
        .overrun      (overrun)
    );

    always #5 Clk = ~Clk;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_mix_q[$];
    int            resp_delay = 1;
    int            resp_cnt   = 0;
    logic [DW-1:0] resp_data  = '0;
    logic          late_ack   = 1'b0;
    logic          mon_req_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sample memory: acks resp_delay cycles after mem_req rises, or once on demand via late_ack.
    initial begin
        mem_ack  = 1'b0;
        mem_data = '0;
        forever begin
            @(posedge Clk);
            #2;
            mem_ack = 1'b0;
            if (late_ack) begin
                mem_ack  = 1'b1;
                mem_data = 16'h7777;
            end else if (mem_req) begin
                if (resp_cnt >= resp_delay) begin
                    mem_ack  = 1'b1;
                    mem_data = resp_data;
                    resp_cnt = 0;
                end else begin
                    resp_cnt++;
                end
            end else begin
                resp_cnt = 0;
            end
        end
    end

    // Monitor: each new request and each mix pulse is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge Clk);
            if (mem_req && !mon_req_prev) begin
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_mem_req: got addr 0x%0h expected no request", mem_addr);
                end else begin
                    check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
                end
            end
            mon_req_prev = mem_req;
            if (mix_valid) begin
                if (exp_mix_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_mix_valid: got mix 0x%0h expected no output", mix_out);
                end else begin
                    check("mix_out", 32'(mix_out), 32'(exp_mix_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    task automatic do_reset();
        @(posedge Clk);
        #1 Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic pulse_trig(input logic [AW-1:0] addr, input logic inv);
        @(posedge Clk);
        #1;
        trig         = 1'b1;
        trig_addr    = addr;
        trig_invalid = inv;
        @(posedge Clk);
        #1;
        trig         = 1'b0;
        trig_invalid = 1'b0;
    endtask

    task automatic pulse_tick();
        @(posedge Clk);
        #1 sample_tick = 1'b1;
        @(posedge Clk);
        #1 sample_tick = 1'b0;
    endtask

    task automatic wait_mix();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge Clk);
            #1;
            if (mix_valid) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL mix_valid_timeout: got no mix_valid expected one within 200 cycles");
        end
    endtask

    task automatic wait_req();
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge Clk);
            #1;
            if (mem_req) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL mem_req_timeout: got no mem_req expected one within 50 cycles");
        end
    endtask

    initial begin
        int cyc;
        Reset        = 1'b1;
        trig         = 1'b0;
        trig_addr    = '0;
        trig_invalid = 1'b0;
        sample_tick  = 1'b0;

        // 1: reset state and empty-frame latency
        do_reset();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mix_out", 32'(mix_out), 0);
        check("rst_mix_valid", 32'(mix_valid), 0);
        check("rst_voice_active", 32'(voice_active), 0);
        check("rst_overrun", 32'(overrun), 0);
        exp_mix_q.push_back(16'h0000);
        pulse_tick();
        cyc = 1;
        while (!mix_valid && cyc < 50) begin
            @(posedge Clk);
            #1;
            cyc++;
        end
        check("empty_frame_latency", 32'(cyc), NV + 2);

        // 2: single voice, address advance between frames
        do_reset();
        resp_delay = 1;
        resp_data  = 16'h1234;
        pulse_trig(20'h79230, 1'b0);
        exp_addr_q.push_back(20'h79230);
        exp_mix_q.push_back(16'h1234);
        pulse_tick();
        wait_mix();
        exp_addr_q.push_back(20'h79231);
        exp_mix_q.push_back(16'h1234);
        pulse_tick();
        wait_mix();

        // 3: positive and negative saturation
        do_reset();
        pulse_trig(20'h60EE0, 1'b0);
        pulse_trig(20'h996F8, 1'b0);
        resp_data = 16'h7000;
        exp_addr_q.push_back(20'h60EE0);
        exp_addr_q.push_back(20'h996F8);
        exp_mix_q.push_back(16'h7FFF);
        pulse_tick();
        wait_mix();
        resp_data = 16'h9000;
        exp_addr_q.push_back(20'h60EE1);
        exp_addr_q.push_back(20'h996F9);
        exp_mix_q.push_back(16'h8000);
        pulse_tick();
        wait_mix();

        // 4: invalid trigger ignored, then voice stealing
        do_reset();
        pulse_trig(20'h11111, 1'b1);
        repeat (3) @(posedge Clk);
        #1;
        check("invalid_trig_active", 32'(voice_active), 0);
        exp_mix_q.push_back(16'h0000);
        pulse_tick();
        wait_mix();
        pulse_trig(20'h01000, 1'b0);
        pulse_trig(20'h02000, 1'b0);
        pulse_trig(20'h03000, 1'b0);
        pulse_trig(20'h04000, 1'b0);
        pulse_trig(20'h05000, 1'b0);
        @(posedge Clk);
        #1;
        check("steal_active", 32'(voice_active), 32'hF);
        resp_data = 16'h0100;
        exp_addr_q.push_back(20'h05000);
        exp_addr_q.push_back(20'h02000);
        exp_addr_q.push_back(20'h03000);
        exp_addr_q.push_back(20'h04000);
        exp_mix_q.push_back(16'h0400);
        pulse_tick();
        wait_mix();

        // 5: voice frees itself after SAMPLE_LEN words; address wraps past the top
        do_reset();
        resp_data = 16'hFFFF;
        pulse_trig(20'hFFFFE, 1'b0);
        for (int f = 0; f < SL; f++) begin
            exp_addr_q.push_back(20'hFFFFE + 20'(f));
            exp_mix_q.push_back(16'hFFFF);
            pulse_tick();
            wait_mix();
            check("len_voice_active", 32'(voice_active), (f < SL - 1) ? 1 : 0);
        end
        exp_mix_q.push_back(16'h0000);
        pulse_tick();
        wait_mix();

        // 6: overrun during WAIT, then reset mid-fetch and a stray late ack
        do_reset();
        resp_delay = 6;
        resp_data  = 16'h0042;
        pulse_trig(20'h00ABC, 1'b0);
        exp_addr_q.push_back(20'h00ABC);
        exp_mix_q.push_back(16'h0042);
        pulse_tick();
        wait_req();
        pulse_tick();
        check("overrun_set", 32'(overrun), 1);
        wait_mix();
        check("overrun_sticky", 32'(overrun), 1);
        check("overrun_voice_active", 32'(voice_active), 1);
        exp_addr_q.push_back(20'h00ABD);
        pulse_tick();
        wait_req();
        @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk);
        #1;
        check("midfetch_rst_mem_req", 32'(mem_req), 0);
        check("midfetch_rst_mem_addr", 32'(mem_addr), 0);
        check("midfetch_rst_overrun", 32'(overrun), 0);
        check("midfetch_rst_active", 32'(voice_active), 0);
        check("midfetch_rst_mix_out", 32'(mix_out), 0);
        Reset = 1'b0;
        late_ack = 1'b1;
        @(posedge Clk);
        #1 late_ack = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("late_ack_mem_req", 32'(mem_req), 0);
        check("late_ack_mix_valid", 32'(mix_valid), 0);
        check("late_ack_active", 32'(voice_active), 0);
        exp_mix_q.push_back(16'h0000);
        pulse_tick();
        wait_mix();

        repeat (3) @(posedge Clk);
        #1;
        check("addr_queue_drained", 32'(exp_addr_q.size()), 0);
        check("mix_queue_drained", 32'(exp_mix_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
